// File: rtl/instruction_fetch_unit.sv
// ----------------------------------------------------------------------------
// instruction_fetch_unit
//   Front end of the pipeline. Holds PC/nPC, issues fetch requests to
//   instruction memory and loads the IF/ID register that feeds decode.
//   Supports MIPS delay-slot redirection from ID, hazard stalls and a
//   one-entry skid buffer. The skid buffer catches a word that returns while
//   decode is stalled.
//
// Ports
//   clk, reset_n                 clock / async active-low reset
//   imem_req, imem_addr          fetch request (combinational from state/PC)
//   imem_ready, imem_rdata       fetch completion and returned word
//   stall                        hold IF/ID contents
//   redirect_valid/_target       taken branch/jump resolved in ID
//   if_id_valid/_instr/_pc       IF/ID pipeline register
//   misalign_err                 one-cycle pulse on a misaligned redirect
// ----------------------------------------------------------------------------
module instruction_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_WORD = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  output logic        if_id_valid,
  output logic [31:0] if_id_instr,
  output logic [31:0] if_id_pc,
  output logic        misalign_err
);

  typedef enum logic [1:0] {
    S_INIT  = 2'd0,
    S_FETCH = 2'd1,
    S_HOLD  = 2'd2
  } state_t;

  state_t      r_state, w_state_nxt;
  logic [31:0] r_pc, r_npc;
  logic [31:0] r_skid_instr, r_skid_pc;
  logic        r_skid_vld;
  logic        r_if_valid;
  logic [31:0] r_if_instr, r_if_pc;
  logic        r_misalign;

  // A redirect only counts while decode is moving; a stalled ID may still be
  // resolving its branch and will reassert the redirect once stall drops.
  logic        w_redir, w_redir_bad, w_redir_ok;
  logic [31:0] w_tgt_p4;

  assign w_redir     = redirect_valid && !stall;
  assign w_redir_bad = w_redir && (redirect_target[1:0] != 2'b00);
  assign w_redir_ok  = w_redir && (redirect_target[1:0] == 2'b00);
  assign w_tgt_p4    = redirect_target + 32'd4;

  // ---------------- FSM: next state and decoded outputs ----------------
  always_comb begin
    w_state_nxt = r_state;
    imem_req    = 1'b0;
    imem_addr   = r_pc;
    case (r_state)
      S_INIT:  w_state_nxt = S_FETCH;
      S_FETCH: begin
        imem_req = 1'b1;
        // Accepted word cannot enter a stalled, occupied IF/ID: park it.
        if (imem_ready && stall && r_if_valid) w_state_nxt = S_HOLD;
      end
      S_HOLD:  if (!stall) w_state_nxt = S_FETCH;
      default: w_state_nxt = S_INIT;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= S_INIT;
    else          r_state <= w_state_nxt;
  end

  // ---------------- datapath ----------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_pc         <= RESET_PC;
      r_npc        <= RESET_PC + 32'd4;
      r_skid_instr <= NOP_WORD;
      r_skid_pc    <= 32'd0;
      r_skid_vld   <= 1'b0;
      r_if_valid   <= 1'b0;
      r_if_instr   <= NOP_WORD;
      r_if_pc      <= 32'd0;
      r_misalign   <= 1'b0;
    end else begin
      r_misalign <= w_redir_bad;
      case (r_state)
        S_FETCH: begin
          if (imem_ready) begin
            if (!stall || !r_if_valid) begin
              r_if_valid <= 1'b1;
              r_if_instr <= imem_rdata;
              r_if_pc    <= r_pc;
            end else begin
              r_skid_instr <= imem_rdata;
              r_skid_pc    <= r_pc;
              r_skid_vld   <= 1'b1;
            end
            // The accepted word is the delay slot, so the target is next.
            if (w_redir_ok) begin
              r_pc  <= redirect_target;
              r_npc <= w_tgt_p4;
            end else begin
              r_pc  <= r_npc;
              r_npc <= r_npc + 32'd4;
            end
          end else begin
            if (!stall) begin
              r_if_valid <= 1'b0;
              r_if_instr <= NOP_WORD;
            end
            // Delay slot still in flight at PC; the target follows it.
            if (w_redir_ok) r_npc <= redirect_target;
          end
        end
        S_HOLD: begin
          if (!stall) begin
            r_if_valid   <= 1'b1;
            r_if_instr   <= r_skid_instr;
            r_if_pc      <= r_skid_pc;
            r_skid_vld   <= 1'b0;
            // Delay slot is the skid word moving into IF/ID right now.
            if (w_redir_ok) begin
              r_pc  <= redirect_target;
              r_npc <= w_tgt_p4;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign if_id_valid  = r_if_valid;
  assign if_id_instr  = r_if_instr;
  assign if_id_pc     = r_if_pc;
  assign misalign_err = r_misalign;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
module tb_instruction_fetch_unit;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic        if_id_valid;
  logic [31:0] if_id_instr;
  logic [31:0] if_id_pc;
  logic        misalign_err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  instruction_fetch_unit #(.RESET_PC(32'h0), .NOP_WORD(32'h0)) dut (
    .clk(clk), .reset_n(reset_n),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ready(imem_ready), .imem_rdata(imem_rdata),
    .stall(stall), .redirect_valid(redirect_valid), .redirect_target(redirect_target),
    .if_id_valid(if_id_valid), .if_id_instr(if_id_instr), .if_id_pc(if_id_pc),
    .misalign_err(misalign_err)
  );

  typedef struct {
    logic        stall;
    logic        ready;
    logic [31:0] rdata;
    logic        rv;
    logic [31:0] tgt;
    logic        e_req;    // during the cycle
    logic [31:0] e_addr;
    logic        e_vld;    // after the edge
    logic [31:0] e_instr;
    logic [31:0] e_pc;
    logic        e_mis;
  } vec_t;

  vec_t tbl[$];

  // instruction word stored at address a (distinct from the address itself)
  function automatic logic [31:0] D(input logic [31:0] a);
    return 32'h1000_0000 ^ a;
  endfunction

  function automatic vec_t v(input logic st, input logic rd, input logic [31:0] rdat,
                             input logic rv, input logic [31:0] tgt,
                             input logic er, input logic [31:0] ea,
                             input logic ev, input logic [31:0] ei,
                             input logic [31:0] ep, input logic em);
    vec_t r;
    r.stall = st; r.ready = rd; r.rdata = rdat; r.rv = rv; r.tgt = tgt;
    r.e_req = er; r.e_addr = ea; r.e_vld = ev; r.e_instr = ei; r.e_pc = ep; r.e_mis = em;
    return r;
  endfunction

  task automatic chk(input string name, input int idx, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s [%0d]: got %h expected %h", name, idx, act, exp);
    end
  endtask

  task automatic chk_reset_vals(input int idx);
    chk("rst_req",   idx, {31'd0, imem_req},     32'd0);
    chk("rst_addr",  idx, imem_addr,             32'd0);
    chk("rst_vld",   idx, {31'd0, if_id_valid},  32'd0);
    chk("rst_instr", idx, if_id_instr,           32'd0);
    chk("rst_pc",    idx, if_id_pc,              32'd0);
    chk("rst_mis",   idx, {31'd0, misalign_err}, 32'd0);
  endtask

  initial begin
    // stall ready rdata rv tgt | req addr | vld instr pc mis
    tbl.push_back(v(0,1,32'hDEAD_BEEF,0,0, 0,32'h0,   0,32'h0,    32'h0,  0)); // INIT ignores ready
    tbl.push_back(v(0,1,D(32'h0),  0,0,    1,32'h0,   1,D(32'h0), 32'h0,  0));
    tbl.push_back(v(0,1,D(32'h4),  0,0,    1,32'h4,   1,D(32'h4), 32'h4,  0));
    tbl.push_back(v(0,1,D(32'h8),  0,0,    1,32'h8,   1,D(32'h8), 32'h8,  0));
    // branch at 0x8 in IF/ID, delay slot 0xC returns same cycle
    tbl.push_back(v(0,1,D(32'hC),  1,32'h100, 1,32'hC,   1,D(32'hC),   32'hC,   0));
    tbl.push_back(v(0,1,D(32'h100),0,0,    1,32'h100, 1,D(32'h100),32'h100,0));
    tbl.push_back(v(0,1,D(32'h104),0,0,    1,32'h104, 1,D(32'h104),32'h104,0));
    // three bubbles, address held
    tbl.push_back(v(0,0,32'h0,     0,0,    1,32'h108, 0,32'h0,    32'h104,0));
    tbl.push_back(v(0,0,32'h0,     0,0,    1,32'h108, 0,32'h0,    32'h104,0));
    tbl.push_back(v(0,0,32'h0,     0,0,    1,32'h108, 0,32'h0,    32'h104,0));
    tbl.push_back(v(0,1,D(32'h108),0,0,    1,32'h108, 1,D(32'h108),32'h108,0));
    // branch at 0x108, delay slot 0x10C still in flight
    tbl.push_back(v(0,0,32'h0,     1,32'h200, 1,32'h10C, 0,32'h0,   32'h108,0));
    tbl.push_back(v(0,1,D(32'h10C),0,0,    1,32'h10C, 1,D(32'h10C),32'h10C,0));
    tbl.push_back(v(0,1,D(32'h200),0,0,    1,32'h200, 1,D(32'h200),32'h200,0));
    // misaligned target: pulse, stay sequential
    tbl.push_back(v(0,1,D(32'h204),1,32'h102, 1,32'h204, 1,D(32'h204),32'h204,1));
    tbl.push_back(v(0,1,D(32'h208),0,0,    1,32'h208, 1,D(32'h208),32'h208,0));
    // stall as 0x20C returns -> skid/HOLD
    tbl.push_back(v(1,1,D(32'h20C),0,0,    1,32'h20C, 1,D(32'h208),32'h208,0));
    tbl.push_back(v(1,1,32'hBAD0_0000,0,0, 0,32'h210, 1,D(32'h208),32'h208,0));
    tbl.push_back(v(0,0,32'h0,     0,0,    0,32'h210, 1,D(32'h20C),32'h20C,0));
    tbl.push_back(v(0,1,D(32'h210),0,0,    1,32'h210, 1,D(32'h210),32'h210,0));
    // redirect while delay slot sits in skid
    tbl.push_back(v(1,1,D(32'h214),0,0,    1,32'h214, 1,D(32'h210),32'h210,0));
    tbl.push_back(v(0,0,32'h0,     1,32'h300, 0,32'h218, 1,D(32'h214),32'h214,0));
    tbl.push_back(v(0,1,D(32'h300),0,0,    1,32'h300, 1,D(32'h300),32'h300,0));
    // redirect under stall is ignored
    tbl.push_back(v(1,0,32'h0,     1,32'h400, 1,32'h304, 1,D(32'h300),32'h300,0));
    tbl.push_back(v(0,1,D(32'h304),0,0,    1,32'h304, 1,D(32'h304),32'h304,0));
    // stall with empty IF/ID still loads
    tbl.push_back(v(0,0,32'h0,     0,0,    1,32'h308, 0,32'h0,    32'h304,0));
    tbl.push_back(v(1,1,D(32'h308),0,0,    1,32'h308, 1,D(32'h308),32'h308,0));
    tbl.push_back(v(0,0,32'h0,     0,0,    1,32'h30C, 0,32'h0,    32'h308,0));
    // 32-bit PC wrap
    tbl.push_back(v(0,1,D(32'h30C),1,32'hFFFF_FFF8, 1,32'h30C, 1,D(32'h30C),32'h30C,0));
    tbl.push_back(v(0,1,D(32'hFFFF_FFF8),0,0, 1,32'hFFFF_FFF8, 1,D(32'hFFFF_FFF8),32'hFFFF_FFF8,0));
    tbl.push_back(v(0,1,D(32'hFFFF_FFFC),0,0, 1,32'hFFFF_FFFC, 1,D(32'hFFFF_FFFC),32'hFFFF_FFFC,0));
    tbl.push_back(v(0,0,32'h0,     0,0,    1,32'h0,   0,32'h0,    32'hFFFF_FFFC,0));

    reset_n = 1'b0; imem_ready = 1'b0; imem_rdata = '0; stall = 1'b0;
    redirect_valid = 1'b0; redirect_target = '0;
    repeat (2) @(posedge clk);
    #1 chk_reset_vals(-1);

    @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < tbl.size(); i++) begin
      stall = tbl[i].stall; imem_ready = tbl[i].ready; imem_rdata = tbl[i].rdata;
      redirect_valid = tbl[i].rv; redirect_target = tbl[i].tgt;
      #1;
      chk("imem_req",  i, {31'd0, imem_req}, {31'd0, tbl[i].e_req});
      chk("imem_addr", i, imem_addr, tbl[i].e_addr);
      @(posedge clk); #1;
      chk("if_id_valid", i, {31'd0, if_id_valid}, {31'd0, tbl[i].e_vld});
      chk("if_id_instr", i, if_id_instr, tbl[i].e_instr);
      chk("if_id_pc",    i, if_id_pc, tbl[i].e_pc);
      chk("misalign",    i, {31'd0, misalign_err}, {31'd0, tbl[i].e_mis});
      @(negedge clk);
    end

    // Async reset mid-request while a misalign pulse is high
    stall = 1'b0; imem_ready = 1'b0; redirect_valid = 1'b1; redirect_target = 32'h102;
    #1 chk("pre_rst_req", 100, {31'd0, imem_req}, 32'd1);
    @(posedge clk); #1;
    redirect_valid = 1'b0;
    chk("pre_rst_mis", 101, {31'd0, misalign_err}, 32'd1);
    #2 reset_n = 1'b0;
    #1 chk_reset_vals(102);

    // INIT after release ignores ready; first request at RESET_PC
    @(negedge clk);
    reset_n = 1'b1; imem_ready = 1'b1; imem_rdata = 32'hDEAD_BEEF;
    #1;
    chk("init_req",  103, {31'd0, imem_req}, 32'd0);
    chk("init_addr", 103, imem_addr, 32'd0);
    @(posedge clk); #1;
    chk("init_vld", 103, {31'd0, if_id_valid}, 32'd0);
    @(negedge clk);
    imem_rdata = D(32'h0);
    #1;
    chk("first_req",  104, {31'd0, imem_req}, 32'd1);
    chk("first_addr", 104, imem_addr, 32'd0);
    @(posedge clk); #1;
    chk("first_vld",   104, {31'd0, if_id_valid}, 32'd1);
    chk("first_instr", 104, if_id_instr, D(32'h0));
    chk("first_pc",    104, if_id_pc, 32'd0);
    @(negedge clk);
    imem_ready = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
